game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
Parametrised round controller that generalises the fixed two-player turn, throw and HP handling to N players. It sequences aim, flight and resolve phases and owns per-player HP with damage saturation. It skips eliminated players, forfeits idle turns on timeout, and declares the winner. It sits between the mouse/throw front end and the simulate/draw_hp_wind back end, clocked by the pixel-domain clock.

Parameters:
N_PLAYERS, 2, number of players (2..8)
HP_W, 7, HP field width per player
HP_MAX, 100, HP loaded at game start (must be < 2**HP_W)
DAMAGE, 20, HP removed per hit
TIMEOUT_CYC, 600000000, AIM-phase cycles before turn forfeit (10 s at 60 MHz); 0 disables timeout
TURN_W, 3, turn counter width

Ports:
clk60MHz  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: begin a new game
throw_req  in  1  one-cycle pulse: current player releases throw
throw_done  in  1  one-cycle pulse: projectile finished (end_throw)
hit_valid  in  1  one-cycle pulse: projectile hit a player
hit_player  in  $clog2(N_PLAYERS)  index of player hit, qualified by hit_valid
current_player  out  $clog2(N_PLAYERS)  player whose turn it is
throw_flag  out  1  high during FLIGHT
turn  out  TURN_W  completed-turn counter
hp_flat  out  N_PLAYERS*HP_W  HP of player i at bits [i*HP_W +: HP_W]
alive  out  N_PLAYERS  bit i set when HP of player i > 0
game_over  out  1  high in OVER
winner  out  $clog2(N_PLAYERS)  valid while game_over
timeout  out  1  one-cycle pulse on turn forfeit

Behaviour:
- Reset (async, any state): state=IDLE. current_player=0, throw_flag=0, turn=0, all HP=0, alive=0, game_over=0, winner=0, timeout=0, timer=0. Reset mid-flight discards the throw with no HP change.
- All outputs are registered. A state change is visible one cycle after the causing input pulse.
- IDLE: on start, load every HP with HP_MAX, alive=all ones, current_player=0, turn=0, go to AIM. Other inputs are ignored.
- AIM: timer increments each cycle.
  - throw_req: throw_flag=1, timer=0, go to FLIGHT.
  - timer==TIMEOUT_CYC-1 (TIMEOUT_CYC≠0) without throw_req: pulse timeout, go to RESOLVE.
  - If both happen in the same cycle, throw_req wins.
  - throw_done and hit_valid are ignored in AIM.
- FLIGHT:
  - hit_valid with hit_player<N_PLAYERS and alive[hit_player]: HP -= DAMAGE, saturating at 0. Multiple hits per flight are allowed. Out-of-range or dead targets are ignored. Self-hit is allowed.
  - throw_done: throw_flag=0, go to RESOLVE.
  - hit_valid and throw_done in the same cycle: the hit is applied, then the block goes to RESOLVE.
  - throw_req is ignored.
- RESOLVE: one cycle.
  - If popcount(alive)<=1: go to OVER. winner = lowest alive index, or current_player if none are alive.
  - Else: turn++ (wraps modulo 2**TURN_W), current_player = next alive index after current_player in ascending order, wrapping N_PLAYERS-1→0. Go to AIM with timer=0.
- OVER: game_over=1; HP and winner are held. start returns to the IDLE load sequence, i.e. directly reinitialises and goes to AIM.
- start is ignored outside IDLE and OVER.
- alive is combinational from registered HP and carries no extra latency.

Test Plan:
- Reset, start, throw_req, 3 cycles, throw_done -> throw_flag high for exactly the flight span; current_player 0→1; turn=1; hp_flat={100,100}.
- N_PLAYERS=2, 5 flights each with hit_valid hit_player=1 -> player1 HP 80,60,40,20,0; after the 5th RESOLVE game_over=1, winner=0.
- DAMAGE=30, HP_MAX=100, 4 hits on one player -> HP 70,40,10,0 (saturates at 0, no wrap); a 5th hit is ignored.
- N_PLAYERS=4 with player 2 killed, then turns advance from player 1 -> current_player goes to 3 (skips 2), then wraps to 0; alive=4'b1011.
- TIMEOUT_CYC=16, no throw_req -> timeout pulses on cycle 16 of AIM; current_player advances; HP unchanged; throw_req arriving in the timeout cycle produces FLIGHT and no timeout pulse.
- Assert rst during FLIGHT after one hit, then start -> all outputs at reset values; after start all HP=100 and current_player=0. Also: hit_valid with hit_player=3 when N_PLAYERS=3 -> no HP change.

Source files
------------

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: N-player round sequencer (aim, flight, resolve) with per-player HP,
// elimination skipping, idle-turn timeout and winner detection.
module game_round_ctrl #(
  parameter int N_PLAYERS = 2,
  parameter int HP_W = 7,
  parameter int HP_MAX = 100,
  parameter int DAMAGE = 20,
  parameter int TIMEOUT_CYC = 600000000,
  parameter int TURN_W = 3,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic                     clk60MHz,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     throw_req,
  input  logic                     throw_done,
  input  logic                     hit_valid,
  input  logic [PW-1:0]            hit_player,
  output logic [PW-1:0]            current_player,
  output logic                     throw_flag,
  output logic [TURN_W-1:0]        turn,
  output logic [N_PLAYERS*HP_W-1:0] hp_flat,
  output logic [N_PLAYERS-1:0]     alive,
  output logic                     game_over,
  output logic [PW-1:0]            winner,
  output logic                     timeout
);
  typedef enum logic [2:0] {IDLE, AIM, FLIGHT, RESOLVE, OVER} state_t;
  state_t state_q;
  logic [TW-1:0] timer_q;
  logic [N_PLAYERS-1:0][HP_W-1:0] hp_q;
  logic [PW-1:0] cur_q, win_q, next_p, low_p, idx;
  logic [TURN_W-1:0] turn_q;
  logic throw_q, over_q, timeout_q, hit_ok;
  always_comb begin
    alive = '0;
    for (int k = 0; k < N_PLAYERS; k++) alive[k] = |hp_q[k];
  end
  // Nearest alive successor: scan from farthest to nearest so the nearest wins.
  always_comb begin
    idx = '0;
    next_p = cur_q;
    low_p = cur_q;
    for (int k = N_PLAYERS - 1; k >= 1; k--) begin
      idx = PW'((int'(cur_q) + k) % N_PLAYERS);
      if (alive[idx]) next_p = idx;
    end
    for (int k = N_PLAYERS - 1; k >= 0; k--) if (alive[k]) low_p = PW'(k);
  end
  assign hit_ok = hit_valid && (int'(hit_player) < N_PLAYERS) && alive[hit_player];
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      hp_q <= '0;
      cur_q <= '0;
      win_q <= '0;
      turn_q <= '0;
      throw_q <= 1'b0;
      over_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, OVER: if (start) begin
          hp_q <= {N_PLAYERS{HP_W'(HP_MAX)}};
          cur_q <= '0;
          win_q <= '0;
          turn_q <= '0;
          timer_q <= '0;
          over_q <= 1'b0;
          state_q <= AIM;
        end
        AIM: if (throw_req) begin
          throw_q <= 1'b1;
          timer_q <= '0;
          state_q <= FLIGHT;
        end else if (TIMEOUT_CYC != 0 && timer_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_q <= 1'b1;
          timer_q <= '0;
          state_q <= RESOLVE;
        end else timer_q <= timer_q + 1'b1;
        FLIGHT: begin
          if (hit_ok) hp_q[hit_player] <= (int'(hp_q[hit_player]) > DAMAGE) ? hp_q[hit_player] - HP_W'(DAMAGE) : '0;
          if (throw_done) begin
            throw_q <= 1'b0;
            state_q <= RESOLVE;
          end
        end
        RESOLVE: if ($countones(alive) <= 1) begin
          over_q <= 1'b1;
          win_q <= low_p;
          state_q <= OVER;
        end else begin
          turn_q <= turn_q + 1'b1;
          cur_q <= next_p;
          timer_q <= '0;
          state_q <= AIM;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign current_player = cur_q;
  assign throw_flag = throw_q;
  assign turn = turn_q;
  assign hp_flat = hp_q;
  assign game_over = over_q;
  assign winner = win_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed checks on three configurations (2p default, 4p/DAMAGE 30/timeout 16, 3p).
module tb_game_round_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, throw_req = 1'b0, throw_done = 1'b0, hit_valid = 1'b0;
  logic [2:0] hit_player = '0;
  logic [1:0] sel = 2'd0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  logic a_cur, a_tf, a_go, a_win, a_to;
  logic [2:0] a_turn;
  logic [13:0] a_hp;
  logic [1:0] a_alive;
  game_round_ctrl u2 (
    .clk60MHz(clk), .rst(rst), .start(start && sel == 2'd0), .throw_req(throw_req && sel == 2'd0),
    .throw_done(throw_done && sel == 2'd0), .hit_valid(hit_valid && sel == 2'd0), .hit_player(hit_player[0:0]),
    .current_player(a_cur), .throw_flag(a_tf), .turn(a_turn), .hp_flat(a_hp), .alive(a_alive),
    .game_over(a_go), .winner(a_win), .timeout(a_to));
  logic [1:0] b_cur, b_win;
  logic b_tf, b_go, b_to;
  logic [2:0] b_turn;
  logic [27:0] b_hp;
  logic [3:0] b_alive;
  game_round_ctrl #(.N_PLAYERS(4), .DAMAGE(30), .TIMEOUT_CYC(16)) u4 (
    .clk60MHz(clk), .rst(rst), .start(start && sel == 2'd1), .throw_req(throw_req && sel == 2'd1),
    .throw_done(throw_done && sel == 2'd1), .hit_valid(hit_valid && sel == 2'd1), .hit_player(hit_player[1:0]),
    .current_player(b_cur), .throw_flag(b_tf), .turn(b_turn), .hp_flat(b_hp), .alive(b_alive),
    .game_over(b_go), .winner(b_win), .timeout(b_to));
  logic [1:0] c_cur, c_win;
  logic c_tf, c_go, c_to;
  logic [2:0] c_turn;
  logic [20:0] c_hp;
  logic [2:0] c_alive;
  game_round_ctrl #(.N_PLAYERS(3)) u3 (
    .clk60MHz(clk), .rst(rst), .start(start && sel == 2'd2), .throw_req(throw_req && sel == 2'd2),
    .throw_done(throw_done && sel == 2'd2), .hit_valid(hit_valid && sel == 2'd2), .hit_player(hit_player[1:0]),
    .current_player(c_cur), .throw_flag(c_tf), .turn(c_turn), .hp_flat(c_hp), .alive(c_alive),
    .game_over(c_go), .winner(c_win), .timeout(c_to));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask
  task automatic flight(input logic h, input logic [2:0] p);
    throw_req = 1'b1; step(); throw_req = 1'b0;
    hit_valid = h; hit_player = p; step(); hit_valid = 1'b0;
    throw_done = 1'b1; step(); throw_done = 1'b0; step();
  endtask
  initial begin
    logic [6:0] hp2;
    step(); step();
    chk("rst_cur", 32'(a_cur), 0);
    chk("rst_tf", 32'(a_tf), 0);
    chk("rst_turn", 32'(a_turn), 0);
    chk("rst_hp", 32'(a_hp), 0);
    chk("rst_alive", 32'(a_alive), 0);
    chk("rst_go", 32'(a_go), 0);
    chk("rst_win", 32'(a_win), 0);
    chk("rst_to", 32'(a_to), 0);
    rst = 1'b0;
    // two players: one clean flight of three cycles
    sel = 2'd0;
    pulse_start();
    chk("start_hp", 32'(a_hp), {7'd100, 7'd100});
    chk("start_alive", 32'(a_alive), 2'b11);
    throw_req = 1'b1; step(); throw_req = 1'b0;
    chk("flag_c1", 32'(a_tf), 1);
    step(); chk("flag_c2", 32'(a_tf), 1);
    step(); chk("flag_c3", 32'(a_tf), 1);
    throw_done = 1'b1; step(); throw_done = 1'b0;
    chk("flag_off", 32'(a_tf), 0);
    chk("resolve_cur", 32'(a_cur), 0);
    step();
    chk("t1_cur", 32'(a_cur), 1);
    chk("t1_turn", 32'(a_turn), 1);
    chk("t1_hp", 32'(a_hp), {7'd100, 7'd100});
    for (int i = 1; i <= 5; i++) begin
      flight(1'b1, 3'd1);
      chk("p1_hp", 32'(a_hp[13:7]), 32'(100 - 20 * i));
      chk("p1_go", 32'(a_go), 32'(i == 5));
    end
    chk("over_win", 32'(a_win), 0);
    chk("over_alive", 32'(a_alive), 2'b01);
    chk("over_turn", 32'(a_turn), 5);
    chk("over_p0", 32'(a_hp[6:0]), 100);
    throw_req = 1'b1; step(); throw_req = 1'b0;
    chk("over_no_throw", 32'(a_tf), 0);
    pulse_start();
    chk("restart_hp", 32'(a_hp), {7'd100, 7'd100});
    chk("restart_go", 32'(a_go), 0);
    chk("restart_turn", 32'(a_turn), 0);
    // four players, DAMAGE 30: kill player 2 and watch the skip
    sel = 2'd1;
    pulse_start();
    hp2 = 7'd100;
    for (int i = 1; i <= 5; i++) begin
      flight(1'b1, 3'd2);
      hp2 = (i <= 3) ? hp2 - 7'd30 : 7'd0;
      chk("p2_hp", 32'(b_hp[20:14]), 32'(hp2));
    end
    chk("dead_alive", 32'(b_alive), 4'b1011);
    chk("after5_cur", 32'(b_cur), 1);
    flight(1'b0, 3'd0);
    chk("skip_cur", 32'(b_cur), 3);
    flight(1'b0, 3'd0);
    chk("wrap_cur", 32'(b_cur), 0);
    chk("turn7", 32'(b_turn), 7);
    flight(1'b0, 3'd0);
    chk("turn_wrap", 32'(b_turn), 0);
    chk("tw_cur", 32'(b_cur), 1);
    repeat (15) step();
    chk("to_early", 32'(b_to), 0);
    step();
    chk("to_pulse", 32'(b_to), 1);
    chk("to_cur_hold", 32'(b_cur), 1);
    step();
    chk("to_clear", 32'(b_to), 0);
    chk("to_cur", 32'(b_cur), 3);
    chk("to_turn", 32'(b_turn), 1);
    chk("to_hp", 32'(b_hp), {7'd100, 7'd0, 7'd100, 7'd100});
    repeat (15) step();
    throw_req = 1'b1; step(); throw_req = 1'b0;
    chk("race_flag", 32'(b_tf), 1);
    chk("race_to", 32'(b_to), 0);
    throw_done = 1'b1; step(); throw_done = 1'b0; step();
    chk("race_cur", 32'(b_cur), 0);
    chk("race_turn", 32'(b_turn), 2);
    // three players: out-of-range hit, then reset mid-flight
    sel = 2'd2;
    pulse_start();
    throw_req = 1'b1; step(); throw_req = 1'b0;
    hit_valid = 1'b1; hit_player = 3'd3; step();
    chk("oor_hp", 32'(c_hp), {7'd100, 7'd100, 7'd100});
    hit_player = 3'd1; step(); hit_valid = 1'b0;
    chk("mid_hp", 32'(c_hp), {7'd100, 7'd80, 7'd100});
    chk("mid_flag", 32'(c_tf), 1);
    rst = 1'b1; #1;
    chk("arst_hp", 32'(c_hp), 0);
    chk("arst_flag", 32'(c_tf), 0);
    chk("arst_alive", 32'(c_alive), 0);
    chk("arst_cur", 32'(c_cur), 0);
    step(); rst = 1'b0;
    pulse_start();
    chk("rs_hp", 32'(c_hp), {7'd100, 7'd100, 7'd100});
    chk("rs_cur", 32'(c_cur), 0);
    chk("rs_flag", 32'(c_tf), 0);
    chk("rs_turn", 32'(c_turn), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
